// File: rtl/pc_pkg.sv
// Shared op encodings for the program-counter / call unit.
package pc_pkg;

  localparam int unsigned PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_OP_HOLD = 3'd0;
  localparam logic [PC_OP_W-1:0] PC_OP_INC  = 3'd1;
  localparam logic [PC_OP_W-1:0] PC_OP_LOAD = 3'd2;
  localparam logic [PC_OP_W-1:0] PC_OP_REL  = 3'd3;
  localparam logic [PC_OP_W-1:0] PC_OP_CALL = 3'd4;
  localparam logic [PC_OP_W-1:0] PC_OP_RET  = 3'd5;
  localparam logic [PC_OP_W-1:0] PC_OP_RSTV = 3'd6;
  localparam logic [PC_OP_W-1:0] PC_OP_RSVD = 3'd7;

endpackage

// File: rtl/pc_call_unit_ret_stack.sv
// Hardware return-address LIFO. PC_STACK_GUARD_EN selects guarded (sticky error)
// versus circular overwrite-oldest behaviour.
module ret_stack #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] pop_data_c,
  output logic                  pop_valid_c,
  output logic                  empty,
  output logic                  full,
  output logic                  err
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, full_q;
  logic                  wr_en;
`ifdef PC_STACK_GUARD_EN
  logic                  err_q, err_d;
`endif

  assign pop_data_c  = mem[wptr_q - PTR_W'(1)];
  assign pop_valid_c = ~empty_q;
  assign empty       = empty_q;
  assign full        = full_q;

  // Pointer/count update; one stack op per cycle at most.
  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
`ifdef PC_STACK_GUARD_EN
    err_d   = err_q;
`endif
    if (push) begin
`ifdef PC_STACK_GUARD_EN
      if (!full_q) begin
        wr_en   = 1'b1;
        wptr_d  = wptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
`else
      wr_en  = 1'b1;
      wptr_d = wptr_q + PTR_W'(1);
      if (!full_q) count_d = count_q + CNT_W'(1);
`endif
    end else if (pop) begin
      if (!empty_q) begin
        wptr_d  = wptr_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
`ifdef PC_STACK_GUARD_EN
      else begin
        err_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
      empty_q <= (count_d == CNT_W'(0));
      full_q  <= (count_d == CNT_W'(STACK_DEPTH));
    end
  end

  // Storage is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wptr_q] <= push_data;
  end

`ifdef PC_STACK_GUARD_EN
  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/pc_call_unit.sv
// Program counter with increment, load, relative branch and CALL/RET via ret_stack.
// Optional guarded stack behaviour under PC_STACK_GUARD_EN.
module pc_call_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DISP_WIDTH   = 8,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_en,
  input  logic [PC_OP_W-1:0]    pc_op,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [DISP_WIDTH-1:0] disp,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_err
);

  localparam logic [ADDR_WIDTH-1:0] RV = ADDR_WIDTH'(RESET_VECTOR);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, disp_ext;
  logic [ADDR_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  do_push, do_pop;

  assign pc_inc   = pc_q + ADDR_WIDTH'(1);
  assign disp_ext = ADDR_WIDTH'($signed(disp));
  assign do_push  = pc_en && (pc_op == PC_OP_CALL);
  assign do_pop   = pc_en && (pc_op == PC_OP_RET);

  ret_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk         (clk),
    .reset       (reset),
    .push        (do_push),
    .pop         (do_pop),
    .push_data   (pc_inc),
    .pop_data_c  (pop_data),
    .pop_valid_c (pop_valid),
    .empty       (stack_empty),
    .full        (stack_full),
    .err         (stack_err)
  );

  // Next-PC select.
  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      case (pc_op)
        PC_OP_INC:  pc_d = pc_inc;
        PC_OP_LOAD: pc_d = pc_in;
        PC_OP_REL:  pc_d = pc_inc + disp_ext;
        PC_OP_CALL: pc_d = pc_in;
        PC_OP_RET: begin
          if (pop_valid) pc_d = pop_data;
`ifdef PC_STACK_GUARD_EN
          else           pc_d = pc_q;
`else
          else           pc_d = RV;
`endif
        end
        PC_OP_RSTV: pc_d = RV;
        default:    pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RV;
    else        pc_q <= pc_d;
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_call_unit.sv
// Scoreboard bench for pc_call_unit: queue-based reference model, directed + random ops.
module tb_pc_call_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en;
  logic [2:0]  pc_op;
  logic [15:0] pc_in;
  logic [7:0]  disp;
  logic [15:0] pc_out;
  logic        stack_empty, stack_full, stack_err;

  always #5 clk = ~clk;

  pc_call_unit #(
    .ADDR_WIDTH   (16),
    .DISP_WIDTH   (8),
    .STACK_DEPTH  (8),
    .RESET_VECTOR (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_en       (pc_en),
    .pc_op       (pc_op),
    .pc_in       (pc_in),
    .disp        (disp),
    .pc_out      (pc_out),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  typedef struct {
    string       tag;
    logic [15:0] pc;
    bit          empty;
    bit          full;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_err;
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;

  // Reference model: stack is a plain queue, oldest at front.
  task automatic step(input bit rst, input bit en, input logic [2:0] op,
                      input logic [15:0] in, input logic [7:0] d, input string tag);
    logic [15:0] ra;
    exp_t e;
    @(negedge clk);
    reset = rst; pc_en = en; pc_op = op; pc_in = in; disp = d;
    ra = m_pc + 16'd1;
    if (!rst) begin
      m_pc = 16'h0000; m_stk.delete(); m_err = 0;
    end else if (en) begin
      case (op)
        3'd1: m_pc = ra;
        3'd2: m_pc = in;
        3'd3: m_pc = ra + {{8{d[7]}}, d};
        3'd4: begin
`ifdef PC_STACK_GUARD_EN
          if (m_stk.size() == 8) m_err = 1;
          else m_stk.push_back(ra);
`else
          if (m_stk.size() == 8) void'(m_stk.pop_front());
          m_stk.push_back(ra);
`endif
          m_pc = in;
        end
        3'd5: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
`ifdef PC_STACK_GUARD_EN
          else m_err = 1;
`else
          else m_pc = 16'h0000;
`endif
        end
        3'd6: m_pc = 16'h0000;
        default: ;
      endcase
    end
    e.tag = tag; e.pc = m_pc;
    e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == 8); e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per applied cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pc_out, stack_empty, stack_full, stack_err} !== {e.pc, e.empty, e.full, e.err}) begin
          errors++;
          $display("FAIL %s: got pc=%h empty=%b full=%b err=%b, expected pc=%h empty=%b full=%b err=%b",
                   e.tag, pc_out, stack_empty, stack_full, stack_err, e.pc, e.empty, e.full, e.err);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; pc_en = 1'b0; pc_op = 3'd0; pc_in = '0; disp = '0;
    m_pc = 16'h0000; m_err = 0;

    step(0, 1, 3'd1, 16'h0000, 8'h00, "reset_inc_0");
    step(0, 1, 3'd1, 16'h0000, 8'h00, "reset_inc_1");

    step(1, 1, 3'd2, 16'h00FF, 8'h00, "load_00ff");
    step(1, 1, 3'd1, 16'h0000, 8'h00, "inc_to_0100");
    step(1, 1, 3'd2, 16'h1234, 8'h00, "load_1234");
    step(1, 1, 3'd3, 16'h0000, 8'hFE, "rel_back");
    step(1, 1, 3'd2, 16'hFFFF, 8'h00, "load_ffff");
    step(1, 1, 3'd1, 16'h0000, 8'h00, "inc_wrap");
    step(1, 1, 3'd3, 16'h0000, 8'h80, "rel_wrap_neg");
    step(1, 1, 3'd3, 16'h0000, 8'h7F, "rel_wrap_pos");

    step(1, 1, 3'd2, 16'h0010, 8'h00, "load_0010");
    step(1, 1, 3'd4, 16'h0200, 8'h00, "call_0200");
    step(1, 1, 3'd4, 16'h0300, 8'h00, "call_0300");
    step(1, 1, 3'd5, 16'h0000, 8'h00, "ret_0201");
    step(1, 1, 3'd5, 16'h0000, 8'h00, "ret_0011");

    for (int i = 1; i <= 9; i++)
      step(1, 1, 3'd4, 16'(i * 16'h0100 + 16'h0005), 8'h00, $sformatf("call_fill_%0d", i));
    for (int i = 1; i <= 9; i++)
      step(1, 1, 3'd5, 16'h0000, 8'h00, $sformatf("ret_drain_%0d", i));

    step(1, 1, 3'd2, 16'h0040, 8'h00, "load_0040");
    step(1, 1, 3'd5, 16'h0000, 8'h00, "ret_empty");

    step(1, 1, 3'd4, 16'h0500, 8'h00, "call_0500");
    step(1, 0, 3'd4, 16'h0777, 8'h00, "gated_call");
    step(1, 1, 3'd0, 16'h0777, 8'h00, "hold");
    step(1, 1, 3'd7, 16'h0777, 8'h00, "reserved");
    step(1, 1, 3'd6, 16'h0777, 8'h00, "rstv");
    step(0, 1, 3'd4, 16'h0888, 8'h00, "reset_vs_call");
    step(1, 1, 3'd5, 16'h0000, 8'h00, "ret_after_reset");

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
           3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), "random");

    @(negedge clk);
    pc_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
